// File: rtl/hdmi_window_capture_pkg.sv
// Shared types and constants for the HDMI window capture block.
package hdmi_window_capture_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int PIXEL_W = 24;
    localparam int COORD_W = 12;
    // One extra bit so offset + span never wraps back into the 12-bit range.
    localparam int ARITH_W = COORD_W + 1;
    localparam int DROP_W  = 8;

endpackage

// File: rtl/hdmi_window_capture_if.sv
// Framebuffer write/status bundle between the capture block and its consumer.
interface hdmi_window_capture_if
    import hdmi_window_capture_pkg::*;
#(
    parameter int ADDR_W = 12
);
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [PIXEL_W-1:0]  wr_data;
    logic                display_bank;
    logic                frame_done;
    logic [DROP_W-1:0]   drop_count;

    modport master (
        output wr_en, wr_addr, wr_data, display_bank, frame_done, drop_count
    );

    modport slave (
        input wr_en, wr_addr, wr_data, display_bank, frame_done, drop_count
    );
endinterface

// File: rtl/hdmi_window_capture_window_match.sv
// One-axis window and decimation match: hit when addr lies in the window on a
// decimation phase of zero; idx is the decimated position inside the window.
module window_match
    import hdmi_window_capture_pkg::*;
#(
    parameter int OFFSET = 0,
    parameter int SPAN   = 64,
    parameter int SHIFT  = 2,
    parameter int IDX_W  = 6
) (
    input  logic [COORD_W-1:0] addr,
    output logic               hit,
    output logic [IDX_W-1:0]   idx
);
    localparam logic [ARITH_W-1:0] LO         = ARITH_W'(OFFSET);
    localparam logic [ARITH_W-1:0] HI         = ARITH_W'(OFFSET + (SPAN << SHIFT));
    localparam logic [ARITH_W-1:0] PHASE_MASK = ARITH_W'((1 << SHIFT) - 1);

    logic [ARITH_W-1:0] wide;
    logic [ARITH_W-1:0] rel;

    assign wide = {1'b0, addr};
    assign rel  = wide - LO;
    assign hit  = (wide >= LO) && (wide < HI) && ((rel & PHASE_MASK) == '0);
    assign idx  = IDX_W'(rel >> SHIFT);
endmodule

// File: rtl/hdmi_window_capture.sv
// Captures a decimated window of an HDMI pixel stream into a double-buffered
// framebuffer write port; the consumer reads display_bank, writes go to the other.
//
// state   | meaning
// SYNC    | waiting for a vsync falling edge with the link valid
// CAPTURE | writing matching pixels of the current frame
// DONE    | last pixel written; flip display bank unless frozen
module hdmi_window_capture
    import hdmi_window_capture_pkg::*;
#(
    parameter int X_OFFSET = 0,
    parameter int Y_OFFSET = 0,
    parameter int WIDTH    = 64,
    parameter int HEIGHT   = 32,
    parameter int SHIFT    = 2,
    localparam int COL_W   = $clog2(WIDTH),
    localparam int ROW_W   = $clog2(HEIGHT),
    localparam int ADDR_W  = 1 + ROW_W + COL_W
) (
    input  logic                hdmi_clk,
    input  logic                hdmi_reset_n,
    input  logic                hdmi_valid,
    input  logic                vsync,
    input  logic                hsync,
    input  logic                rgb_valid,
    input  logic [7:0]          r,
    input  logic [7:0]          g,
    input  logic [7:0]          b,
    input  logic [COORD_W-1:0]  hdmi_xaddr,
    input  logic [COORD_W-1:0]  hdmi_yaddr,
    input  logic                freeze,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [PIXEL_W-1:0]  wr_data,
    output logic                display_bank,
    output logic                frame_done,
    output logic [DROP_W-1:0]   drop_count
);
    state_t             state;
    state_t             state_nxt;
    logic               last_vsync;
    logic               vsync_fall;
    logic               x_hit;
    logic               y_hit;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               last_pix;
    logic               accept;
    logic               drop;
    logic               unused_hsync;

    assign unused_hsync = hsync;

    window_match #(
        .OFFSET (X_OFFSET),
        .SPAN   (WIDTH),
        .SHIFT  (SHIFT),
        .IDX_W  (COL_W)
    ) u_match_x (
        .addr   (hdmi_xaddr),
        .hit    (x_hit),
        .idx    (col)
    );

    window_match #(
        .OFFSET (Y_OFFSET),
        .SPAN   (HEIGHT),
        .SHIFT  (SHIFT),
        .IDX_W  (ROW_W)
    ) u_match_y (
        .addr   (hdmi_yaddr),
        .hit    (y_hit),
        .idx    (row)
    );

    assign vsync_fall = last_vsync & ~vsync;
    assign frame_done = (state == DONE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        last_pix  = (col == COL_W'(WIDTH - 1)) && (row == ROW_W'(HEIGHT - 1));
        unique case (state)
            SYNC: begin
                if (vsync_fall && hdmi_valid) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                // Link loss outranks a simultaneous vsync edge.
                if (!hdmi_valid) begin
                    drop      = 1'b1;
                    state_nxt = SYNC;
                end else if (vsync_fall) begin
                    drop      = 1'b1;
                    state_nxt = CAPTURE;
                end else if (rgb_valid && x_hit && y_hit) begin
                    accept = 1'b1;
                    if (last_pix) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = SYNC;
            end
            default: begin
                state_nxt = SYNC;
            end
        endcase
    end

    always_ff @(posedge hdmi_clk or negedge hdmi_reset_n) begin
        if (!hdmi_reset_n) begin
            state        <= SYNC;
            last_vsync   <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            display_bank <= 1'b0;
            drop_count   <= '0;
        end else begin
            state      <= state_nxt;
            last_vsync <= vsync;
            wr_en      <= accept;
            if (accept) begin
                wr_addr <= {~display_bank, row, col};
                wr_data <= {r, g, b};
            end
            if (drop && (drop_count != {DROP_W{1'b1}})) begin
                drop_count <= drop_count + 1'b1;
            end
            if ((state == DONE) && !freeze) begin
                display_bank <= ~display_bank;
            end
        end
    end
endmodule

// File: tb/tb_hdmi_window_capture.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops them.
module tb_hdmi_window_capture;
    import hdmi_window_capture_pkg::*;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdmi_valid, vsync, hsync, rgb_valid, freeze;
    logic [7:0]  r, g, b;
    logic [11:0] xa, ya;

    always #5 clk = ~clk;

    hdmi_window_capture_if #(.ADDR_W(AW)) bus0 ();
    hdmi_window_capture_if #(.ADDR_W(AW)) bus1 ();
    hdmi_window_capture_if #(.ADDR_W(AW)) bus2 ();

    hdmi_window_capture u_dut0 (
        .hdmi_clk(clk), .hdmi_reset_n(rst_n), .hdmi_valid(hdmi_valid),
        .vsync(vsync), .hsync(hsync), .rgb_valid(rgb_valid),
        .r(r), .g(g), .b(b), .hdmi_xaddr(xa), .hdmi_yaddr(ya), .freeze(freeze),
        .wr_en(bus0.wr_en), .wr_addr(bus0.wr_addr), .wr_data(bus0.wr_data),
        .display_bank(bus0.display_bank), .frame_done(bus0.frame_done),
        .drop_count(bus0.drop_count)
    );

    hdmi_window_capture #(.X_OFFSET(100), .Y_OFFSET(50), .SHIFT(0)) u_dut1 (
        .hdmi_clk(clk), .hdmi_reset_n(rst_n), .hdmi_valid(hdmi_valid),
        .vsync(vsync), .hsync(hsync), .rgb_valid(rgb_valid),
        .r(r), .g(g), .b(b), .hdmi_xaddr(xa), .hdmi_yaddr(ya), .freeze(freeze),
        .wr_en(bus1.wr_en), .wr_addr(bus1.wr_addr), .wr_data(bus1.wr_data),
        .display_bank(bus1.display_bank), .frame_done(bus1.frame_done),
        .drop_count(bus1.drop_count)
    );

    hdmi_window_capture #(.X_OFFSET(4000), .SHIFT(2)) u_dut2 (
        .hdmi_clk(clk), .hdmi_reset_n(rst_n), .hdmi_valid(hdmi_valid),
        .vsync(vsync), .hsync(hsync), .rgb_valid(rgb_valid),
        .r(r), .g(g), .b(b), .hdmi_xaddr(xa), .hdmi_yaddr(ya), .freeze(freeze),
        .wr_en(bus2.wr_en), .wr_addr(bus2.wr_addr), .wr_data(bus2.wr_data),
        .display_bank(bus2.display_bank), .frame_done(bus2.frame_done),
        .drop_count(bus2.drop_count)
    );

    int xo [3] = '{0, 100, 4000};
    int yo [3] = '{0, 50, 0};
    int sh [3] = '{2, 0, 2};

    bit          cap  [3];
    bit          bank [3];
    int          drop_exp, done_exp;
    int          done_cnt, wr_cnt0;
    int          checks, errors;
    logic [35:0] q0 [$];
    logic [35:0] q1 [$];
    logic [35:0] q2 [$];

    function automatic bit in_win(input int a, input int off, input int s,
                                  input int n, output int idx);
        idx = 0;
        if (a < off) return 1'b0;
        if (a >= off + n * (1 << s)) return 1'b0;
        if (((a - off) % (1 << s)) != 0) return 1'b0;
        idx = (a - off) / (1 << s);
        return 1'b1;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push(input int k, input logic [35:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pix(input int x, input int y);
        int col, row;
        bit hx, hy;
        rgb_valid = 1'b1;
        xa = 12'(x);
        ya = 12'(y);
        r  = 8'(x);
        g  = 8'(y);
        b  = {4'(x >> 8), 4'(y >> 8)};
        for (int k = 0; k < 3; k++) begin
            hx = in_win(x, xo[k], sh[k], 64, col);
            hy = in_win(y, yo[k], sh[k], 32, row);
            if (cap[k] && hx && hy) begin
                push(k, {~bank[k], 5'(row), 6'(col), r, g, b});
                if (k == 0 && col == 63 && row == 31) begin
                    cap[0] = 1'b0;
                    done_exp++;
                    if (!freeze) bank[0] = ~bank[0];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rgb_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic vfall();
        rgb_valid = 1'b0;
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (hdmi_valid) begin
                if (k == 0 && cap[0]) drop_exp++;
                cap[k] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic row_pixels(input int y);
        for (int xi = 0; xi < 64; xi++) pix(xi * 4, y);
    endtask

    // Sparse ramp frame: only the decimation-grid pixels plus edge probes.
    task automatic frame(input int abort_yi);
        vfall();
        for (int yi = 0; yi <= 32; yi++) begin
            if (yi == abort_yi) begin
                hdmi_valid = 1'b0;
                rgb_valid  = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    if (cap[k]) begin
                        if (k == 0) drop_exp++;
                        cap[k] = 1'b0;
                    end
                end
                @(negedge clk);
                hdmi_valid = 1'b1;
                idle(2);
                return;
            end
            rgb_valid = 1'b0;
            hsync = 1'b1;
            @(negedge clk);
            hsync = 1'b0;
            if (yi == 1) pix(0, 1);
            if (yi == 13) begin
                pix(99, 50); pix(100, 50); pix(101, 50); pix(164, 50);
            end
            row_pixels(yi * 4);
            pix(1, yi * 4);
            pix(256, yi * 4);
            if (yi == 0) begin
                pix(3996, 0); pix(4000, 0); pix(4092, 0);
            end
        end
        idle(3);
    endtask

    task automatic sb(input int k, input logic en, input logic [AW-1:0] a,
                      input logic [23:0] d);
        logic [35:0] e;
        bit          have;
        if (en !== 1'b1) return;
        checks++;
        have = 1'b1;
        case (k)
            0: if (q0.size() == 0) have = 1'b0; else e = q0.pop_front();
            1: if (q1.size() == 0) have = 1'b0; else e = q1.pop_front();
            default: if (q2.size() == 0) have = 1'b0; else e = q2.pop_front();
        endcase
        if (!have) begin
            errors++;
            $display("FAIL unexpected_write dut%0d: got addr %h data %h expected no write", k, a, d);
        end else if ({a, d} !== e) begin
            errors++;
            $display("FAIL write dut%0d: got addr %h data %h expected addr %h data %h",
                     k, a, d, e[35:24], e[23:0]);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus0.wr_en === 1'b1) wr_cnt0++;
            sb(0, bus0.wr_en, bus0.wr_addr, bus0.wr_data);
            sb(1, bus1.wr_en, bus1.wr_addr, bus1.wr_data);
            sb(2, bus2.wr_en, bus2.wr_addr, bus2.wr_data);
            if (bus0.frame_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (!(bus0.wr_en === 1'b1 && bus0.wr_addr[10:0] === 11'h7FF)) begin
                    errors++;
                    $display("FAIL done_with_last_write: got wr_en %b addr %h expected 1 and xx7ff",
                             bus0.wr_en, bus0.wr_addr);
                end
            end
        end
    end

    task automatic frame_end_checks(input string tag, input int wr_before, input int wr_exp);
        check({tag, "_q0_empty"}, q0.size(), 0);
        check({tag, "_q1_empty"}, q1.size(), 0);
        check({tag, "_q2_empty"}, q2.size(), 0);
        check({tag, "_writes"}, wr_cnt0 - wr_before, wr_exp);
        check({tag, "_frame_done"}, done_cnt, done_exp);
        check({tag, "_bank"}, int'(bus0.display_bank), int'(bank[0]));
        check({tag, "_drop"}, int'(bus0.drop_count), drop_exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr_en"}, int'(bus0.wr_en), 0);
        check({tag, "_wr_addr"}, int'(bus0.wr_addr), 0);
        check({tag, "_wr_data"}, int'(bus0.wr_data), 0);
        check({tag, "_bank"}, int'(bus0.display_bank), 0);
        check({tag, "_frame_done"}, int'(bus0.frame_done), 0);
        check({tag, "_drop"}, int'(bus0.drop_count), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int wb;
        rst_n = 1'b0; hdmi_valid = 1'b1; vsync = 1'b0; hsync = 1'b0;
        rgb_valid = 1'b0; freeze = 1'b0; r = '0; g = '0; b = '0; xa = '0; ya = '0;
        for (int k = 0; k < 3; k++) begin cap[k] = 1'b0; bank[k] = 1'b0; end
        drop_exp = 0; done_exp = 0; done_cnt = 0; wr_cnt0 = 0; checks = 0; errors = 0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        idle(3);

        wb = wr_cnt0; frame(99); frame_end_checks("frame1", wb, 2048);
        check("frame1_bank_is_1", int'(bus0.display_bank), 1);

        wb = wr_cnt0; frame(10); frame_end_checks("abort", wb, 640);
        check("abort_drop_is_1", int'(bus0.drop_count), 1);

        wb = wr_cnt0; frame(99); frame_end_checks("recover", wb, 2048);

        freeze = 1'b1;
        wb = wr_cnt0; frame(99); frame_end_checks("freeze1", wb, 2048);
        wb = wr_cnt0; frame(99); frame_end_checks("freeze2", wb, 2048);
        check("freeze_bank_is_0", int'(bus0.display_bank), 0);
        freeze = 1'b0;

        wb = wr_cnt0; frame(99); frame_end_checks("unfrozen", wb, 2048);

        // Abandon a frame by reset part way through row 0.
        vfall();
        row_pixels(0);
        idle(1);
        #2;
        vsync = 1'b1;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        for (int k = 0; k < 3; k++) begin cap[k] = 1'b0; bank[k] = 1'b0; end
        drop_exp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        vsync = 1'b0;
        idle(2);
        wb = wr_cnt0;
        row_pixels(0);
        row_pixels(4);
        idle(2);
        check("no_write_before_vsync", wr_cnt0 - wb, 0);

        wb = wr_cnt0; frame(99); frame_end_checks("post_reset", wb, 2048);
        check("post_reset_drop_is_0", int'(bus0.drop_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdmi_window_capture.md
HDMI_WINDOW_CAPTURE -- requirements
Module: hdmi_window_capture

Interface
REQ-001 SHALL have parameter X_OFFSET, default 0: first captured hdmi_xaddr.
REQ-002 SHALL have parameter Y_OFFSET, default 0: first captured hdmi_yaddr.
REQ-003 SHALL have parameter WIDTH, default 64: output columns; power of two.
REQ-004 SHALL have parameter HEIGHT, default 32: output rows; power of two.
REQ-005 SHALL have parameter SHIFT, default 2: log2 decimation factor, applied to both axes.
REQ-006 SHALL have ports, in this order:
- hdmi_clk  in  1  sole clock.
- hdmi_reset_n  in  1  asynchronous, active-low reset.
- hdmi_valid  in  1  TMDS link valid.
- vsync  in  1  vertical sync.
- hsync  in  1  horizontal sync (unused except in the bench).
- rgb_valid  in  1  pixel qualifier.
- r, g, b  in  8 each  pixel colour.
- hdmi_xaddr, hdmi_yaddr  in  12 each  pixel coordinate.
- freeze  in  1  holds the display bank.
- wr_en  out  1  framebuffer write strobe.
- wr_addr  out  1+log2(HEIGHT)+log2(WIDTH)  {bank,row,col}.
- wr_data  out  24  {r,g,b}.
- display_bank  out  1  bank the consumer reads.
- frame_done  out  1  one-cycle pulse.
- drop_count  out  8  aborted frames.

Function
REQ-007 SHALL implement FSM states SYNC, CAPTURE and DONE.
REQ-008 SYNC: SHALL move to CAPTURE on a vsync falling edge (registered last_vsync high, vsync low) while hdmi_valid is high.
REQ-009 CAPTURE: SHALL accept a pixel when all of the following hold: rgb_valid=1; X_OFFSET <= hdmi_xaddr < X_OFFSET+(WIDTH<<SHIFT); same rule for y; low SHIFT bits of both (addr-offset) are 0.
REQ-010 Each accepted pixel SHALL produce wr_en=1 exactly one cycle later, with:
- col=(xaddr-X_OFFSET)>>SHIFT;
- row=(yaddr-Y_OFFSET)>>SHIFT;
- bank=~display_bank;
- wr_data={r,g,b} registered.
REQ-011 Window arithmetic SHALL be done at 13 bits so an offset plus span cannot wrap past 4095; coordinates beyond 4095 are never matched.
REQ-012 Accepting the last pixel (col=WIDTH-1, row=HEIGHT-1) SHALL move to DONE in the same cycle that pixel's write is registered.
REQ-013 DONE SHALL last one cycle and:
- pulse frame_done=1;
- toggle display_bank unless freeze=1;
- return to SYNC.
REQ-014 If hdmi_valid=0 in CAPTURE, the FSM SHALL go to SYNC and increment drop_count, saturating at 255; display_bank SHALL NOT change.
REQ-015 A vsync falling edge in CAPTURE before the last pixel SHALL count as a drop and restart CAPTURE directly.
REQ-016 If hdmi_valid=0 and a vsync falling edge occur in the same cycle in CAPTURE, the FSM SHALL take REQ-014 only.
REQ-017 In SYNC and DONE, wr_en SHALL be 0 except for the registered write of the final pixel.
REQ-018 freeze SHALL be sampled only in DONE; it SHALL NOT suppress writes.

Reset
REQ-019 hdmi_reset_n=0 SHALL force, immediately and asynchronously:
- state=SYNC;
- wr_en=0, wr_addr=0, wr_data=0;
- display_bank=0, frame_done=0, drop_count=0, last_vsync=0.
REQ-020 Reset asserted mid-CAPTURE SHALL abandon the frame and SHALL NOT increment drop_count.
REQ-021 After reset release, the first capture SHALL need a fresh vsync falling edge.

Structure
REQ-022 A shared package SHALL hold the state encoding (SYNC=0, CAPTURE=1, DONE=2) and the 24-bit pixel width constant.
REQ-023 The window/decimation match SHALL be one sub-module, window_match, instantiated once per axis.
REQ-024 The block SHALL contain no memory; the framebuffer lives downstream.

Verification
REQ-025 Defaults, 640x480 ramp frame, hdmi_valid=1:
- 2048 writes, first wr_addr={1,0,0};
- last write {1,31,63} carries pixel (252,124);
- frame_done pulses once;
- display_bank=1.
REQ-026 X_OFFSET=100, Y_OFFSET=50, SHIFT=0: first write carries pixel (100,50); no write for x=99 or x=164.
REQ-027 Drop hdmi_valid at row 10 of the window: drop_count=1, display_bank unchanged, no frame_done; the next full frame completes normally.
REQ-028 freeze=1 over two full frames: frame_done pulses twice; display_bank stays 0; all writes target bank 1.
REQ-029 Assert hdmi_reset_n=0 mid-CAPTURE: all outputs are 0 within the same cycle; drop_count stays 0; no write until the next vsync falling edge.
REQ-030 X_OFFSET=4000, SHIFT=2: no wrap; no write for xaddr<4000.
